// File: rtl/cram_loader_pkg.sv
// cram_loader_pkg: shared state encoding and sizing helper for the CRAM loader
package cram_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} loader_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cram_deserializer.sv
// cram_deserializer: assembles bits leaving the chain tail into host-width readback words
module cram_deserializer
  import cram_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              last_i,
  input  logic              bit_i,
  output logic              word_end_o,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o
);
  localparam int IW = idx_w(WORD_W);
  logic [WORD_W-1:0] acc_q, acc_d, acc_set, rd_q, rd_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              vld_q, vld_d, flush;
  assign word_end_o = idx_q == IW'(WORD_W - 1);
  assign rd_data_o  = rd_q;
  assign rd_valid_o = vld_q && en_i;
  // a word closes on its WORD_W-th bit or on the final chain bit; the accumulator restarts empty
  always_comb begin
    acc_set = acc_q | (WORD_W'(bit_i) << idx_q);
    flush   = shift_i && (last_i || word_end_o);
    acc_d   = (clr_i || flush) ? '0 : shift_i ? acc_set : acc_q;
    idx_d   = (clr_i || flush) ? '0 : shift_i ? idx_q + 1'b1 : idx_q;
    rd_d    = flush ? acc_set : rd_q;
    vld_d   = flush;
  end
  // state advances only while the fabric is enabled so a pending pulse survives a freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      rd_q  <= rd_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: rtl/cram_loader.sv
// cram_loader: serialises host bitstream words onto the CRAM config chain and reads back its tail
module cram_loader
  import cram_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 320,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              config_en,
  output logic              config_data_out,
  input  logic              config_data_in,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);
  loader_state_t     state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q, word_end, last, idle_like;
  assign idle_like       = state_q == IDLE || state_q == DONE;
  assign last            = cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign config_en       = en && state_q == SHIFT;
  assign config_data_out = config_en && shreg_q[0];
  assign wr_ready        = en && state_q == LOAD;
  assign busy            = state_q == LOAD || state_q == SHIFT;
  assign done            = done_q;
  assign bit_count       = cnt_q;
  // sequencer: abort overrides every transition, en low freezes all state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (en) begin
      if (abort) begin
        state_q <= IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: if (start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
          LOAD: if (wr_valid) begin
            shreg_q <= wr_data;
            state_q <= SHIFT;
          end
          SHIFT: begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (word_end) state_q <= LOAD;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  cram_deserializer #(.WORD_W(WORD_W)) u_deser (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .clr_i     (en && (abort || (start && idle_like))),
    .shift_i   (config_en && !abort),
    .last_i    (last),
    .bit_i     (config_data_in),
    .word_end_o(word_end),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid)
  );
endmodule

// File: tb/tb_cram_loader.sv
// tb_cram_loader: randomized scoreboard bench for cram_loader driving a behavioural config chain
module tb_cram_loader;
  localparam int L  = 20;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;
  localparam int CW = $clog2(L + 1);
  logic clk = 0, rst = 1, en = 0, start = 0, abort = 0, wr_valid = 0;
  logic [W-1:0] wr_data = '0, rd_data;
  logic wr_ready, config_en, config_data_out, config_data_in, rd_valid, busy, done;
  logic [CW-1:0] bit_count;
  logic [L-1:0] chain = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] words[NW];
  int total = 0, bad = 0, ce_cycles = 0, ce_bursts = 0;
  logic ce_prev = 0;

  always #5 clk = ~clk;

  cram_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .config_en(config_en), .config_data_out(config_data_out), .config_data_in(config_data_in),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .bit_count(bit_count)
  );

  // fabric stand-in: head at chain[0], tail at chain[L-1]
  assign config_data_in = chain[L-1];
  always @(posedge clk) begin
    if (config_en) chain <= {chain[L-2:0], config_data_out};
    if (config_en) ce_cycles <= ce_cycles + 1;
    if (config_en && !ce_prev) ce_bursts <= ce_bursts + 1;
    ce_prev <= config_en;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // scoreboard monitor: every readback pulse must match the oldest expected word
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got %0h want none", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  function automatic logic [L-1:0] exp_chain();
    logic [L-1:0] c = '0;
    for (int i = 0; i < L; i++) c[L-1-i] = words[i/W][i%W];
    return c;
  endfunction

  task automatic chk_zero(input string n);
    chk({n, "_wr_ready"}, wr_ready, 0);
    chk({n, "_config_en"}, config_en, 0);
    chk({n, "_cdo"}, config_data_out, 0);
    chk({n, "_rd_valid"}, rd_valid, 0);
    chk({n, "_rd_data"}, rd_data, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_bit_count"}, bit_count, 0);
  endtask

  task automatic wait_ready(input string n);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (wr_ready !== 1'b1 && g < 100);
    chk(n, wr_ready, 1);
  endtask

  task automatic present(input logic [W-1:0] d);
    wr_data  = d;
    wr_valid = 1;
    wait_ready("accept");
    @(posedge clk);
    #1;
    wr_valid = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run_load(input int stall, input bit drop);
    logic [L-1:0] snap;
    logic [W-1:0] v;
    int c0, b0, g;
    snap = chain;
    for (int j = 0; j < NW; j++) begin
      v = '0;
      for (int b = 0; b < W; b++) if (j * W + b < L) v[b] = snap[L-1-(j*W+b)];
      exp_q.push_back(v);
    end
    pulse_start();
    c0 = ce_cycles;
    b0 = ce_bursts;
    for (int j = 0; j < NW; j++) begin
      if (j > 0 && stall > 0) begin
        wait_ready("ready_stall");
        repeat (stall) begin
          @(posedge clk);
          @(negedge clk);
          chk("stall_cfg_en", config_en, 0);
        end
        @(posedge clk);
        #1;
      end
      present(words[j]);
      if (drop && j == 0) begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        en = 0;
        repeat (3) begin
          @(negedge clk);
          chk("frz_cnt", bit_count, 2);
          chk("frz_cfg_en", config_en, 0);
          @(posedge clk);
        end
        #1;
        en = 1;
      end
    end
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (done !== 1'b1 && g < 200);
    chk("done", done, 1);
    chk("bit_count", bit_count, L);
    chk("chain", chain, exp_chain());
    chk("ce_cycles", ce_cycles - c0, L);
    if (!drop) chk("ce_bursts", ce_bursts - b0, NW);
  endtask

  // five bits shifted, then abort (or reset); no readback word is owed
  task automatic partial(input bit use_rst);
    pulse_start();
    present(words[0]);
    repeat (5) @(posedge clk);
    #1;
    if (use_rst) rst = 1;
    else abort = 1;
    @(posedge clk);
    #1;
    rst = 0;
    abort = 0;
    @(negedge clk);
    if (use_rst) chk_zero("rst_mid");
    else begin
      chk("abort_busy", busy, 0);
      chk("abort_cfg_en", config_en, 0);
      chk("abort_done", done, 0);
      chk("abort_wr_ready", wr_ready, 0);
      chk("abort_cnt", bit_count, 5);
    end
  endtask

  initial begin
    logic [L-1:0] cfg;
    en = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk_zero("reset");
    words = '{8'hA5, 8'h3C, 8'hF7};
    run_load(0, 0);
    @(posedge clk);
    #1;
    wr_valid = 1;
    repeat (2) begin
      @(negedge clk);
      chk("done_wr_ready", wr_ready, 0);
      chk("done_sticky", done, 1);
    end
    @(posedge clk);
    #1;
    wr_valid = 0;
    words = '{8'h00, 8'h80, 8'h00};
    run_load(0, 0);
    for (int k = 0; k < L; k++) cfg[k] = chain[L-1-k];
    chk("le_reg_mode", cfg[16], 0);
    for (int s = 0; s < 16; s++) chk("le_out", cfg[16] ? 1'b0 : cfg[s], s == 15);
    words = '{8'hA5, 8'h3C, 8'hF7};
    run_load(5, 0);
    run_load(0, 0);
    partial(0);
    run_load(0, 0);
    run_load(0, 1);
    partial(1);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      run_load(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
